// File: rtl/kernel_launch_sequencer.sv
// kernel_launch_sequencer
//
// Drives the ap_start / ap_ready / ap_done handshake of a generated kernel
// wrapper. It launches the kernel num_runs times back to back and records
// the latency of each run. A per-run watchdog flags a kernel that never
// reports ap_done.
//
// Ports:
//   clk          clock
//   rst          asynchronous, active-high reset
//   launch       request pulse, accepted only in IDLE or ERR
//   abort        return to IDLE from any state; wins over every other event
//   num_runs     number of runs, latched when a launch is accepted
//   ap_ready     kernel can accept a start
//   ap_done      kernel finished (one-cycle pulse)
//   ap_start     start request to the kernel (registered)
//   busy         high while in START or WAIT
//   run_idx      0-based index of the current / final run
//   last_cycles  latency of the most recently completed run
//   done         one-cycle pulse after the last run completes
//   timeout_err  sticky watchdog error, cleared by launch or abort
module kernel_launch_sequencer #(
  parameter int RUN_W   = 8,
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             launch,
  input  logic             abort,
  input  logic [RUN_W-1:0] num_runs,
  input  logic             ap_ready,
  input  logic             ap_done,
  output logic             ap_start,
  output logic             busy,
  output logic [RUN_W-1:0] run_idx,
  output logic [CNT_W-1:0] last_cycles,
  output logic             done,
  output logic             timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_DONE,
    S_ERR
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT);
  localparam logic             WDOG_EN     = (TIMEOUT != 0);

  state_t           state;
  logic [RUN_W-1:0] runs;   // run count latched at launch
  logic [CNT_W-1:0] cnt;    // cycles since acceptance of the current run

  logic accept;
  logic last_run;
  logic cnt_sat;

  // The handshake completes on the registered ap_start, so a start can only
  // be accepted once it is actually visible to the kernel.
  assign accept   = ap_start & ap_ready;
  assign last_run = (run_idx == (runs - RUN_W'(1)));
  assign cnt_sat  = &cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      runs        <= '0;
      cnt         <= '0;
      ap_start    <= 1'b0;
      busy        <= 1'b0;
      run_idx     <= '0;
      last_cycles <= '0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        // The kernel is left running; a later launch waits in START for
        // ap_ready, which naturally absorbs the orphaned run.
        state       <= S_IDLE;
        ap_start    <= 1'b0;
        busy        <= 1'b0;
        timeout_err <= 1'b0;
      end else begin
        case (state)
          S_IDLE, S_ERR: begin
            if (launch) begin
              timeout_err <= 1'b0;
              run_idx     <= '0;
              runs        <= num_runs;
              if (num_runs == '0) begin
                state <= S_DONE;
              end else begin
                state <= S_START;
                busy  <= 1'b1;
              end
            end
          end

          S_START: begin
            // ap_start rises one cycle after entering START and stays up
            // until accepted; there is no watchdog on acceptance.
            if (accept) begin
              ap_start <= 1'b0;
              cnt      <= CNT_W'(1);
              state    <= S_WAIT;
            end else begin
              ap_start <= 1'b1;
            end
          end

          S_WAIT: begin
            // ap_done takes precedence over the watchdog firing in the
            // same cycle.
            if (ap_done) begin
              last_cycles <= cnt;
              if (last_run) begin
                state <= S_DONE;
                busy  <= 1'b0;
              end else begin
                run_idx <= run_idx + RUN_W'(1);
                state   <= S_START;
              end
            end else if (WDOG_EN && (cnt == TIMEOUT_VAL)) begin
              timeout_err <= 1'b1;
              busy        <= 1'b0;
              state       <= S_ERR;
            end else if (!cnt_sat) begin
              cnt <= cnt + CNT_W'(1);
            end
          end

          S_DONE: begin
            done  <= 1'b1;
            state <= S_IDLE;
          end

          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_kernel_launch_sequencer.sv
`timescale 1ns/1ps
// Scoreboard bench for kernel_launch_sequencer. The main process issues
// jobs and pushes the expected events; a kernel process emulates the
// wrapper; a monitor process pops and compares when the DUT presents events.
module tb_kernel_launch_sequencer;
  localparam int RUN_W   = 8;
  localparam int CNT_W   = 32;
  localparam int TIMEOUT = 16;

  logic             clk = 1'b0;
  logic             rst, launch, abort, ap_ready, ap_done;
  logic [RUN_W-1:0] num_runs;
  logic             ap_start, busy, done, timeout_err;
  logic [RUN_W-1:0] run_idx;
  logic [CNT_W-1:0] last_cycles;

  always #5 clk = ~clk;

  kernel_launch_sequencer #(.RUN_W(RUN_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .launch(launch), .abort(abort), .num_runs(num_runs),
    .ap_ready(ap_ready), .ap_done(ap_done), .ap_start(ap_start), .busy(busy),
    .run_idx(run_idx), .last_cycles(last_cycles), .done(done),
    .timeout_err(timeout_err)
  );

  typedef struct { int idx; int last; int stall; } acc_t;
  typedef struct { int idx; int last; bit chk_idx; bit zero; } done_t;
  typedef struct { int delay; int stall; } kjob_t;
  typedef struct { string name; logic [3:0] flags; int idx; int last; } snap_t;

  acc_t  acc_q[$];
  done_t done_q[$];
  int    err_q[$];
  kjob_t kq[$];
  snap_t snap_q[$];

  int vectors = 0, miscompares = 0;
  int model_last = 0;
  int job_delay[16];
  int job_stall[16];
  int kflush_req = 0;
  int tmo_req = 0;
  bit zero_chk = 1'b0;
  bit fin_req = 1'b0;
  bit fin_done = 1'b0;

  // ---------------- kernel model (decides its inputs at negedge) ----------
  initial begin : kernel
    bit    has_job, running;
    int    rem, stall, delay, flush_seen;
    kjob_t j;
    has_job = 0; running = 0; rem = 0; stall = 0; delay = 0; flush_seen = 0;
    ap_ready = 1'b1;
    ap_done  = 1'b0;
    forever begin
      @(negedge clk);
      if (kflush_req != flush_seen) begin
        flush_seen = kflush_req;
        has_job = 0;
        running = 0;
      end
      ap_done = 1'b0;
      if (running) begin
        ap_ready = 1'b0;
        if (delay != 0) begin          // delay 0 models a hung kernel
          rem--;
          if (rem == 0) begin
            ap_done = 1'b1;
            running = 0;
          end
        end
      end else if (ap_start === 1'b1) begin
        if (!has_job) begin
          if (kq.size() > 0) j = kq.pop_front();
          else begin j.delay = 1; j.stall = 0; end
          delay = j.delay; stall = j.stall; has_job = 1;
        end
        if (stall > 0) begin
          ap_ready = 1'b0;
          stall--;
        end else begin
          ap_ready = 1'b1;
          has_job = 0;
          running = 1;
          rem = delay;
        end
      end else begin
        ap_ready = 1'b1;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------------------------
  initial begin : monitor
    int    cyc, acc_cyc, done_cyc, launch_cyc, start_hi, tmo_seen, lat;
    bit    prev_acc, prev_done, prev_err;
    acc_t  a;
    done_t d;
    snap_t s;
    int    e;
    cyc = 0; acc_cyc = -100; done_cyc = -100; launch_cyc = -100;
    start_hi = 0; tmo_seen = 0; prev_acc = 0; prev_done = 0; prev_err = 0;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (tmo_req != tmo_seen) begin
        tmo_seen = tmo_req;
        vectors++; miscompares++;
        $display("FAIL wait_budget: got pending events after cycle budget, want all consumed");
      end
      if (snap_q.size() > 0) begin
        s = snap_q.pop_front();
        vectors++;
        if ({ap_start, busy, done, timeout_err} !== s.flags ||
            run_idx !== RUN_W'(s.idx) || last_cycles !== CNT_W'(s.last)) begin
          miscompares++;
          $display("FAIL %s: got start/busy/done/err=%b run_idx=%0d last=%0d, want %b %0d %0d",
                   s.name, {ap_start, busy, done, timeout_err}, run_idx, last_cycles,
                   s.flags, s.idx, s.last);
        end
      end
      if (zero_chk) begin
        vectors++;
        if (ap_start !== 1'b0 || busy !== 1'b0) begin
          miscompares++;
          $display("FAIL zero_run_idle: got ap_start=%b busy=%b, want 0 0", ap_start, busy);
        end
      end
      if (prev_acc) begin
        vectors++;
        if (ap_start !== 1'b0) begin
          miscompares++;
          $display("FAIL start_drop: got ap_start=%b after acceptance, want 0", ap_start);
        end
      end
      if (prev_done) begin
        vectors++;
        if (done !== 1'b0) begin
          miscompares++;
          $display("FAIL done_width: got done=%b in second cycle, want 0", done);
        end
      end
      if (launch === 1'b1) launch_cyc = cyc;
      if (ap_start === 1'b1) start_hi++;
      if (ap_start === 1'b1 && ap_ready === 1'b1) begin
        vectors++;
        if (acc_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_accept: got acceptance run_idx=%0d, want none", run_idx);
        end else begin
          a = acc_q.pop_front();
          if (run_idx !== RUN_W'(a.idx) || last_cycles !== CNT_W'(a.last) ||
              start_hi != a.stall + 1 || timeout_err !== 1'b0) begin
            miscompares++;
            $display("FAIL accept: got run_idx=%0d last=%0d start_cycles=%0d err=%b, want %0d %0d %0d 0",
                     run_idx, last_cycles, start_hi, timeout_err, a.idx, a.last, a.stall + 1);
          end
        end
        start_hi = 0;
        acc_cyc = cyc;
      end
      prev_acc = (ap_start === 1'b1 && ap_ready === 1'b1);
      if (ap_done === 1'b1) done_cyc = cyc;
      if (done === 1'b1) begin
        vectors++;
        if (done_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_done: got done pulse, want none");
        end else begin
          d = done_q.pop_front();
          lat = d.zero ? (cyc - launch_cyc) : (cyc - done_cyc);
          if ((d.chk_idx && run_idx !== RUN_W'(d.idx)) || last_cycles !== CNT_W'(d.last) ||
              lat != 2 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL done_pulse: got run_idx=%0d last=%0d delay=%0d busy=%b, want %0d %0d 2 0",
                     run_idx, last_cycles, lat, busy, d.idx, d.last);
          end
        end
      end
      prev_done = (done === 1'b1);
      if (timeout_err === 1'b1 && !prev_err) begin
        vectors++;
        if (err_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_timeout: got timeout_err rise, want none");
        end else begin
          e = err_q.pop_front();
          if (cyc - acc_cyc != TIMEOUT + 1 || run_idx !== RUN_W'(e)) begin
            miscompares++;
            $display("FAIL timeout_time: got rise %0d cycles after accept run_idx=%0d, want %0d %0d",
                     cyc - acc_cyc, run_idx, TIMEOUT + 1, e);
          end
        end
      end
      prev_err = (timeout_err === 1'b1);
      if (fin_req && !fin_done) begin
        vectors++;
        if (acc_q.size() + done_q.size() + err_q.size() != 0) begin
          miscompares++;
          $display("FAIL leftover: got %0d unconsumed expectations, want 0",
                   acc_q.size() + done_q.size() + err_q.size());
        end
        fin_done = 1'b1;
      end
    end
  end

  // ---------------- stimulus and reference model --------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_snap(input string name, input logic [3:0] flags, input int idx, input int last);
    snap_t s;
    s.name = name; s.flags = flags; s.idx = idx; s.last = last;
    snap_q.push_back(s);
  endtask

  // Expected events of a job: one acceptance per run (carrying the previous
  // latency), then either a done pulse or a watchdog error on a run whose
  // kernel latency exceeds the limit.
  task automatic prep_job(input int n);
    int    prev;
    bit    hung;
    acc_t  a;
    done_t d;
    kjob_t k;
    prev = model_last;
    hung = 0;
    for (int r = 0; r < n; r++) begin
      a.idx = r; a.last = prev; a.stall = job_stall[r];
      acc_q.push_back(a);
      k.delay = job_delay[r]; k.stall = job_stall[r];
      kq.push_back(k);
      if (job_delay[r] == 0 || job_delay[r] > TIMEOUT) begin
        err_q.push_back(r);
        hung = 1;
        break;
      end
      prev = job_delay[r];
    end
    if (!hung) begin
      d.idx = (n == 0) ? 0 : n - 1; d.last = prev; d.chk_idx = (n != 0); d.zero = (n == 0);
      done_q.push_back(d);
      model_last = prev;
    end
  endtask

  task automatic pulse_launch(input int n);
    num_runs = RUN_W'(n);
    launch = 1'b1;
    tick();
    launch = 1'b0;
  endtask

  task automatic wait_job();
    int k;
    k = 0;
    while ((acc_q.size() + done_q.size() + err_q.size()) != 0 && k < 3000) begin
      tick();
      k++;
    end
    if (k >= 3000) begin
      tmo_req++;
      acc_q.delete(); done_q.delete(); err_q.delete();
    end
    tick();
    tick();
  endtask

  task automatic kernel_flush();
    kq.delete();
    kflush_req++;
  endtask

  task automatic run_job(input int n);
    prep_job(n);
    pulse_launch(n);
    wait_job();
  endtask

  task automatic wait_in_wait();
    int k;
    k = 0;
    while (ap_start !== 1'b1 && k < 200) begin tick(); k++; end
    while (ap_start !== 1'b0 && k < 400) begin tick(); k++; end
  endtask

  initial begin : main
    int saved, k;
    rst = 1'b1; launch = 1'b0; abort = 1'b0; num_runs = '0;
    for (int i = 0; i < 16; i++) begin job_delay[i] = 1; job_stall[i] = 0; end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    push_snap("reset_state", 4'b0000, 0, 0);
    tick();

    // three runs of latency 5
    for (int i = 0; i < 3; i++) begin job_delay[i] = 5; job_stall[i] = 0; end
    run_job(3);

    // zero runs: done without any start
    zero_chk = 1'b1;
    run_job(0);
    zero_chk = 1'b0;

    // hung kernel trips the watchdog; error is sticky
    job_delay[0] = 0; job_stall[0] = 0;
    run_job(1);
    push_snap("err_sticky", 4'b0001, 0, model_last);
    repeat (5) tick();
    push_snap("err_hold", 4'b0001, 0, model_last);
    tick();
    kernel_flush();
    tick();
    job_delay[0] = 3;
    run_job(1);
    push_snap("err_cleared", 4'b0000, 0, 3);
    tick();

    // latency exactly at the limit completes; one beyond errors
    job_delay[0] = TIMEOUT; job_delay[1] = 1; job_stall[0] = 0; job_stall[1] = 0;
    run_job(2);
    job_delay[0] = TIMEOUT + 1;
    run_job(1);
    kernel_flush();
    tick();

    // ap_ready held low 10 cycles while ap_start is up
    job_delay[0] = 4; job_stall[0] = 10;
    run_job(1);

    // launch with a new count during WAIT is ignored
    job_delay[0] = 8; job_delay[1] = 8; job_stall[0] = 0; job_stall[1] = 1;
    prep_job(2);
    pulse_launch(2);
    wait_in_wait();
    num_runs = RUN_W'(7);
    launch = 1'b1;
    tick();
    launch = 1'b0;
    wait_job();

    // randomized jobs within the watchdog limit
    for (int j = 0; j < 20; j++) begin
      int n;
      n = $urandom_range(1, 4);
      for (int r = 0; r < n; r++) begin
        job_delay[r] = $urandom_range(1, TIMEOUT);
        job_stall[r] = $urandom_range(0, 3);
      end
      run_job(n);
    end

    // abort in WAIT coinciding with ap_done
    job_delay[0] = 6; job_delay[1] = 6; job_stall[0] = 0; job_stall[1] = 0;
    saved = model_last;
    prep_job(2);
    model_last = saved;
    pulse_launch(2);
    k = 0;
    while (k < 200) begin
      @(negedge clk);
      #2;
      if (ap_done === 1'b1) break;
      k++;
    end
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    acc_q.delete(); done_q.delete();
    kernel_flush();
    push_snap("abort_idle", 4'b0000, 0, saved);
    repeat (6) tick();

    // asynchronous reset in the middle of WAIT
    job_delay[0] = 12; job_stall[0] = 0;
    prep_job(1);
    pulse_launch(1);
    wait_in_wait();
    repeat (3) tick();
    rst = 1'b1;
    push_snap("async_reset", 4'b0000, 0, 0);
    acc_q.delete(); done_q.delete(); err_q.delete();
    kernel_flush();
    model_last = 0;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // recovery after reset
    job_delay[0] = 4; job_stall[0] = 2;
    run_job(1);

    fin_req = 1'b1;
    k = 0;
    while (!fin_done && k < 20) begin tick(); k++; end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/kernel_launch_sequencer.md
Name: kernel_launch_sequencer

Overview:
- Drives the ap_start/ap_ready/ap_done handshake of a generated top-level kernel wrapper. Launches the kernel NUM back-to-back times per software/testbench request.
- Measures the latency of each run and flags a hung kernel with a watchdog.
- Sits between the host-side control/CSR logic and the kernel wrapper's ap_* ports; it is the only driver of ap_start.

Parameters:
- RUN_W, 8, width of run count and run index.
- CNT_W, 32, width of latency counter and latched latency.
- TIMEOUT, 4096, watchdog limit in cycles per run; 0 disables the watchdog.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- launch  in  1  request pulse; sampled only in IDLE or ERR.
- abort  in  1  forces return to IDLE from any state.
- num_runs  in  RUN_W  runs to perform; sampled on the accepted launch.
- ap_ready  in  1  kernel idle / able to accept start.
- ap_done  in  1  kernel finished; one-cycle pulse.
- ap_start  out  1  start request to kernel.
- busy  out  1  high in START or WAIT.
- run_idx  out  RUN_W  index of the current run (0-based).
- last_cycles  out  CNT_W  latency of the most recently completed run.
- done  out  1  one-cycle pulse when all runs are complete.
- timeout_err  out  1  sticky watchdog error.

Behaviour:
- Reset (asynchronous, active-high): state=IDLE; ap_start=0, busy=0, run_idx=0, last_cycles=0, done=0, timeout_err=0; internal counters=0.
- States:
  - IDLE: launch with num_runs≠0 → latch num_runs, run_idx=0 → START. Launch with num_runs=0 → DONE, and ap_start never asserts.
  - START: ap_start=1. On ap_start&&ap_ready (acceptance edge): cnt←1 → WAIT. ap_done seen in START is ignored.
  - WAIT: ap_start=0.
    - ap_done → last_cycles←cnt. If run_idx==latched−1 → DONE; else run_idx+1 → START.
    - Else if TIMEOUT≠0 and cnt==TIMEOUT → timeout_err←1 → ERR.
    - Else cnt←cnt+1, saturating at all-ones.
  - DONE: done=1 for exactly one cycle → IDLE. run_idx holds its final value.
  - ERR: ap_start=0, busy=0. launch clears timeout_err and behaves as in IDLE. abort → IDLE with timeout_err cleared.
- Latency definition: acceptance in cycle t and ap_done in cycle t+k ⇒ last_cycles=k (k≥1).
- ap_start is registered and asserts in the cycle after entering START. Between consecutive runs it deasserts for at least the WAIT→START transition cycle. The kernel's ap_ready returns the cycle after ap_done.
- ap_start holds high in START until accepted; no timeout applies in START.
- launch while busy or in DONE is ignored; num_runs changes while busy have no effect.
- abort has priority over every other event in the same cycle. abort in WAIT leaves the kernel running; a following launch waits in START until ap_ready.
- ap_done and the timeout condition in the same cycle: ap_done wins, no error.
- Asynchronous reset mid-run returns all outputs to their reset values immediately.

Test Plan:
1. Kernel model: ap_done 5 cycles after acceptance; num_runs=3, launch pulse → exactly 3 ap_start acceptances; run_idx 0,1,2; last_cycles=5 after each run; single done pulse after the 3rd ap_done; ap_start low for ≥1 cycle between runs.
2. num_runs=0, launch → done pulse 2 cycles later; ap_start never high; busy never high.
3. TIMEOUT=16, kernel never asserts ap_done → timeout_err=1 when cnt=16 and stays high. Second launch with a responsive kernel (done after 3) → timeout_err cleared; last_cycles=3; done pulse.
4. ap_ready held low for 10 cycles in START → ap_start stays high 10+ cycles; no acceptance; no error. Release → run proceeds normally.
5. Launch pulse during WAIT of run 0 with num_runs changed to 7 → ignored; original count of 2 runs completes.
6. abort in WAIT with ap_done in the same cycle → IDLE; last_cycles unchanged; no done pulse. Asynchronous rst asserted mid-WAIT → all outputs 0 before the next clock edge.
